// File: rtl/hazard_sequencer.sv
// -----------------------------------------------------------------------------
// hazard_sequencer
//
// Pipeline control for the 8-bit pipelined processor. Watches hazard sources in
// the D, E and M stages and drives the hold / clear controls of the IF/ID,
// ID/EX, EX/MEM and MEM/WB stage registers.
//
// Handled events, in priority order while running normally:
//   1. data-memory wait (mem_req_M && !mem_ready) : freeze whole pipe
//   2. taken branch in E                           : flush D and E
//   3. load-use between E load and D sources       : one-cycle stall + E bubble
//   4. interrupt request                           : drain, then vector
//
// Memory handshake: mem_req_M marks an access in M; the access completes in
// the cycle mem_ready is high. A request with mem_ready already high in the
// same cycle completes without any stall.
//
// Parameters
//   MEM_TIMEOUT  (1..255) stall cycles of one memory wait before forced release
//   DRAIN_CYCLES (1..7)   fetch-suppression cycles before interrupt vectoring
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous, active-low reset
//   rs1_D, rs2_D   decode source register addresses
//   rs1_used_D,
//   rs2_used_D     decode instruction really reads that source
//   rd_E           execute destination register
//   rd_en_E        execute instruction is a load
//   wr_en_regf_E   execute instruction writes the register file
//   branch_taken_E branch resolved taken in execute
//   mem_req_M      memory stage accesses data memory
//   mem_ready      data memory completes the access this cycle
//   intr           level-sensitive interrupt request
//   stall_F/D/E/M  hold PC / IF-ID / ID-EX / EX-MEM
//   flush_D/E      clear IF/ID / ID/EX to NOP at next edge
//   bubble_W       zero the MEM/WB control bits
//   pc_sel_intr    select interrupt vector as next PC
//   int_ack        one-cycle interrupt acknowledge
//   mem_err        sticky memory-timeout flag
//   stall_cnt      saturating count of cycles with stall_F high
//   state_dbg      current FSM state (RUN=0, MEM_WAIT=1, INT_DRAIN=2, INT_VEC=3)
// -----------------------------------------------------------------------------
module hazard_sequencer #(
   parameter int unsigned MEM_TIMEOUT  = 15,
   parameter int unsigned DRAIN_CYCLES = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] rs1_D,
   input  logic [1:0] rs2_D,
   input  logic       rs1_used_D,
   input  logic       rs2_used_D,
   input  logic [1:0] rd_E,
   input  logic       rd_en_E,
   input  logic       wr_en_regf_E,
   input  logic       branch_taken_E,
   input  logic       mem_req_M,
   input  logic       mem_ready,
   input  logic       intr,
   output logic       stall_F,
   output logic       stall_D,
   output logic       stall_E,
   output logic       stall_M,
   output logic       flush_D,
   output logic       flush_E,
   output logic       bubble_W,
   output logic       pc_sel_intr,
   output logic       int_ack,
   output logic       mem_err,
   output logic [7:0] stall_cnt,
   output logic [1:0] state_dbg
);

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      MEM_WAIT  = 2'd1,
      INT_DRAIN = 2'd2,
      INT_VEC   = 2'd3
   } state_t;

   localparam logic [7:0] TIMEOUT_V  = 8'(MEM_TIMEOUT);
   localparam logic [2:0] DRAIN_LAST = 3'(DRAIN_CYCLES - 1);

   state_t     state, state_nxt;
   logic [7:0] wait_cnt, wait_cnt_nxt;
   logic [2:0] drain_cnt, drain_cnt_nxt;

   logic mem_stall_req;
   logic load_use;
   logic timeout_hit;

   // raw (un-gated) control terms
   logic freeze;      // full pipeline freeze for a memory wait
   logic hold_fd;     // stall_F + stall_D only
   logic hold_f;      // stall_F only
   logic clr_d;
   logic clr_e;
   logic vec;

   assign mem_stall_req = mem_req_M && !mem_ready;

   assign load_use = rd_en_E && wr_en_regf_E &&
                     (((rd_E == rs1_D) && rs1_used_D) ||
                      ((rd_E == rs2_D) && rs2_used_D));

   always_comb begin
      state_nxt     = state;
      wait_cnt_nxt  = wait_cnt;
      drain_cnt_nxt = drain_cnt;
      timeout_hit   = 1'b0;
      freeze        = 1'b0;
      hold_fd       = 1'b0;
      hold_f        = 1'b0;
      clr_d         = 1'b0;
      clr_e         = 1'b0;
      vec           = 1'b0;

      unique case (state)
         RUN: begin
            if (mem_stall_req) begin
               freeze       = 1'b1;
               state_nxt    = MEM_WAIT;
               wait_cnt_nxt = 8'd1;     // this cycle is the first wait cycle
            end else if (branch_taken_E) begin
               // decode holds a wrong-path instruction, so any load-use
               // against it is irrelevant
               clr_d = 1'b1;
               clr_e = 1'b1;
            end else if (load_use) begin
               hold_fd = 1'b1;
               clr_e   = 1'b1;
            end else if (intr) begin
               state_nxt     = INT_DRAIN;
               drain_cnt_nxt = 3'd0;
            end
         end

         MEM_WAIT: begin
            if (mem_ready) begin
               state_nxt = RUN;
            end else if (wait_cnt == TIMEOUT_V) begin
               // wait_cnt equals the number of stall cycles already spent
               timeout_hit = 1'b1;
               state_nxt   = RUN;
            end else begin
               freeze       = 1'b1;
               wait_cnt_nxt = wait_cnt + 8'd1;
            end
         end

         INT_DRAIN: begin
            if (mem_stall_req) begin
               // freeze without counting a drain cycle
               freeze = 1'b1;
            end else begin
               hold_f = 1'b1;
               clr_d  = 1'b1;
               if (drain_cnt == DRAIN_LAST) begin
                  state_nxt = INT_VEC;
               end else begin
                  drain_cnt_nxt = drain_cnt + 3'd1;
               end
            end
         end

         INT_VEC: begin
            vec       = 1'b1;
            clr_d     = 1'b1;
            state_nxt = RUN;
         end

         default: state_nxt = RUN;
      endcase
   end

   // every control output is forced low while reset is held
   assign stall_F     = reset && (freeze || hold_fd || hold_f);
   assign stall_D     = reset && (freeze || hold_fd);
   assign stall_E     = reset && freeze;
   assign stall_M     = reset && freeze;
   assign bubble_W    = reset && freeze;
   assign flush_D     = reset && clr_d;
   assign flush_E     = reset && clr_e;
   assign pc_sel_intr = reset && vec;
   assign int_ack     = reset && vec;
   assign state_dbg   = state;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= RUN;
         wait_cnt  <= 8'd0;
         drain_cnt <= 3'd0;
         mem_err   <= 1'b0;
         stall_cnt <= 8'd0;
      end else begin
         state     <= state_nxt;
         wait_cnt  <= wait_cnt_nxt;
         drain_cnt <= drain_cnt_nxt;
         if (timeout_hit) begin
            mem_err <= 1'b1;
         end
         if (stall_F && (stall_cnt != 8'hFF)) begin
            stall_cnt <= stall_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_hazard_sequencer.sv
// -----------------------------------------------------------------------------
// tb_hazard_sequencer
//
// Directed scenarios for each hazard class followed by randomized traffic.
// A behavioural model tracks the pipeline-control situation in plain terms
// (which episode is active, stall cycles spent, drain cycles remaining) and
// predicts every control output, mem_err, stall_cnt and the debug state.
// Inputs change just after the falling edge; outputs are sampled 2 ns later.
// -----------------------------------------------------------------------------
module tb_hazard_sequencer;

   localparam int MEM_TIMEOUT  = 15;
   localparam int DRAIN_CYCLES = 3;

   // model situations, numbered like the debug state output
   localparam int S_RUN   = 0;
   localparam int S_WAIT  = 1;
   localparam int S_DRAIN = 2;
   localparam int S_VEC   = 3;

   // clock / reset
   logic clk;
   logic reset;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // DUT signals
   logic [1:0] rs1_D, rs2_D, rd_E;
   logic       rs1_used_D, rs2_used_D, rd_en_E, wr_en_regf_E;
   logic       branch_taken_E, mem_req_M, mem_ready, intr;
   logic       stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, bubble_W;
   logic       pc_sel_intr, int_ack, mem_err;
   logic [7:0] stall_cnt;
   logic [1:0] state_dbg;

   logic [8:0] ctl_bus;
   assign ctl_bus = {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E,
                     bubble_W, pc_sel_intr, int_ack};

   hazard_sequencer #(
      .MEM_TIMEOUT (MEM_TIMEOUT),
      .DRAIN_CYCLES(DRAIN_CYCLES)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .rs1_D         (rs1_D),
      .rs2_D         (rs2_D),
      .rs1_used_D    (rs1_used_D),
      .rs2_used_D    (rs2_used_D),
      .rd_E          (rd_E),
      .rd_en_E       (rd_en_E),
      .wr_en_regf_E  (wr_en_regf_E),
      .branch_taken_E(branch_taken_E),
      .mem_req_M     (mem_req_M),
      .mem_ready     (mem_ready),
      .intr          (intr),
      .stall_F       (stall_F),
      .stall_D       (stall_D),
      .stall_E       (stall_E),
      .stall_M       (stall_M),
      .flush_D       (flush_D),
      .flush_E       (flush_E),
      .bubble_W      (bubble_W),
      .pc_sel_intr   (pc_sel_intr),
      .int_ack       (int_ack),
      .mem_err       (mem_err),
      .stall_cnt     (stall_cnt),
      .state_dbg     (state_dbg)
   );

   // scoreboard counters
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // behavioural model state
   int         m_sit;      // current situation
   int         m_spent;    // stall cycles spent in the current memory wait
   int         m_left;     // counted drain cycles still owed
   bit         m_err;
   int         m_scount;
   logic [8:0] exp_ctl;
   int         n_sit, n_spent, n_left;
   bit         n_err;
   int         n_scount;
   logic [8:0] obs_ctl;

   task automatic model_reset();
      m_sit    = S_RUN;
      m_spent  = 0;
      m_left   = 0;
      m_err    = 0;
      m_scount = 0;
   endtask

   // expected controls for the current inputs, plus the situation after the edge
   task automatic model_eval();
      bit want_sf, want_sd, want_freeze, want_fd, want_fe, want_vec;
      bit mem_blocked, hazard_lu;
      mem_blocked = mem_req_M && !mem_ready;
      hazard_lu   = rd_en_E && wr_en_regf_E &&
                    ((rd_E == rs1_D && rs1_used_D) || (rd_E == rs2_D && rs2_used_D));
      want_sf = 0; want_sd = 0; want_freeze = 0;
      want_fd = 0; want_fe = 0; want_vec = 0;
      n_sit = m_sit; n_spent = m_spent; n_left = m_left; n_err = m_err;

      if (m_sit == S_RUN) begin
         if (mem_blocked) begin
            want_freeze = 1; n_sit = S_WAIT; n_spent = 1;
         end else if (branch_taken_E) begin
            want_fd = 1; want_fe = 1;
         end else if (hazard_lu) begin
            want_sf = 1; want_sd = 1; want_fe = 1;
         end else if (intr) begin
            n_sit = S_DRAIN; n_left = DRAIN_CYCLES;
         end
      end else if (m_sit == S_WAIT) begin
         if (mem_ready) begin
            n_sit = S_RUN;
         end else if (m_spent == MEM_TIMEOUT) begin
            n_err = 1; n_sit = S_RUN;
         end else begin
            want_freeze = 1; n_spent = m_spent + 1;
         end
      end else if (m_sit == S_DRAIN) begin
         if (mem_blocked) begin
            want_freeze = 1;
         end else begin
            want_sf = 1; want_fd = 1;
            n_left = m_left - 1;
            if (n_left == 0) n_sit = S_VEC;
         end
      end else begin
         want_vec = 1; want_fd = 1; n_sit = S_RUN;
      end

      if (want_freeze) begin
         want_sf = 1; want_sd = 1;
      end
      exp_ctl = {want_sf, want_sd, want_freeze, want_freeze, want_fd, want_fe,
                 want_freeze, want_vec, want_vec};
      n_scount = (want_sf && m_scount < 255) ? m_scount + 1 : m_scount;
   endtask

   // one clock: called just after a falling edge with inputs applied
   task automatic cycle();
      #2;
      model_eval();
      obs_ctl = ctl_bus;
      check_eq("ctl",       32'(ctl_bus),   32'(exp_ctl));
      check_eq("mem_err",   32'(mem_err),   32'(m_err));
      check_eq("stall_cnt", 32'(stall_cnt), 32'(m_scount));
      check_eq("state",     32'(state_dbg), 32'(m_sit));
      @(posedge clk);
      m_sit = n_sit; m_spent = n_spent; m_left = n_left;
      m_err = n_err; m_scount = n_scount;
      @(negedge clk);
   endtask

   task automatic drive_idle();
      rs1_D = 2'd0; rs2_D = 2'd0; rd_E = 2'd0;
      rs1_used_D = 1'b0; rs2_used_D = 1'b0;
      rd_en_E = 1'b0; wr_en_regf_E = 1'b0;
      branch_taken_E = 1'b0; mem_req_M = 1'b0; mem_ready = 1'b0; intr = 1'b0;
   endtask

   task automatic drive_load_use(input bit used);
      rd_en_E = 1'b1; wr_en_regf_E = 1'b1; rd_E = 2'd2;
      rs1_D = 2'd2; rs1_used_D = used;
      rs2_D = 2'd1; rs2_used_D = 1'b1;
   endtask

   int ack_idx;
   int ready_pct;

   initial begin
      // reset state, with hazard-looking inputs that must not leak through
      reset = 1'b0;
      drive_idle();
      mem_req_M = 1'b1; branch_taken_E = 1'b1; intr = 1'b1;
      model_reset();
      #1;
      check_eq("rst_ctl",   32'(ctl_bus),   32'd0);
      check_eq("rst_cnt",   32'(stall_cnt), 32'd0);
      check_eq("rst_err",   32'(mem_err),   32'd0);
      check_eq("rst_state", 32'(state_dbg), 32'd0);
      @(negedge clk);
      drive_idle();
      reset = 1'b1;
      cycle();

      // load-use: one stall cycle
      drive_load_use(1'b1);
      cycle();
      check_eq("lu_ctl", 32'(obs_ctl), 32'h188);
      drive_idle();
      cycle();
      check_eq("lu_after", 32'(obs_ctl), 32'h000);
      check_eq("lu_cnt", 32'(stall_cnt), 32'd1);

      // same registers but rs1 not read: no stall
      drive_load_use(1'b0);
      cycle();
      check_eq("nouse_ctl", 32'(obs_ctl), 32'h000);
      drive_idle();

      // branch together with load-use: flushes win
      drive_load_use(1'b1);
      branch_taken_E = 1'b1;
      cycle();
      check_eq("br_ctl", 32'(obs_ctl), 32'h018);
      drive_idle();
      cycle();
      check_eq("br_cnt", 32'(stall_cnt), 32'd1);

      // 4-cycle memory wait, released on the 5th
      mem_req_M = 1'b1; mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cycle();
         check_eq("mw_frozen", 32'(obs_ctl), 32'h1E4);
      end
      mem_ready = 1'b1;
      cycle();
      check_eq("mw_release", 32'(obs_ctl), 32'h000);
      drive_idle();
      cycle();
      check_eq("mw_state", 32'(state_dbg), 32'd0);
      check_eq("mw_cnt", 32'(stall_cnt), 32'd5);

      // timeout: 15 stall cycles, then forced release
      mem_req_M = 1'b1; mem_ready = 1'b0;
      for (int i = 0; i < MEM_TIMEOUT + 1; i++) cycle();
      check_eq("to_drop", 32'(obs_ctl), 32'h000);
      drive_idle();
      cycle();
      check_eq("to_err", 32'(mem_err), 32'd1);
      check_eq("to_cnt", 32'(stall_cnt), 32'd20);

      // interrupt in idle run, request dropped after one cycle
      ack_idx = -1;
      for (int i = 0; i < 6; i++) begin
         intr = (i == 0);
         cycle();
         if (obs_ctl[0]) ack_idx = i;
      end
      check_eq("int_ack_at", 32'(ack_idx), 32'(DRAIN_CYCLES + 1));
      check_eq("int_cnt", 32'(stall_cnt), 32'd23);

      // interrupt with a 2-cycle memory wait during drain
      ack_idx = -1;
      for (int i = 0; i < 8; i++) begin
         intr = (i == 0);
         mem_req_M = (i == 2 || i == 3);
         cycle();
         if (obs_ctl[0]) ack_idx = i;
      end
      drive_idle();
      check_eq("int_mw_ack_at", 32'(ack_idx), 32'(DRAIN_CYCLES + 3));
      check_eq("int_mw_cnt", 32'(stall_cnt), 32'd28);
      check_eq("err_sticky", 32'(mem_err), 32'd1);

      // asynchronous reset in the middle of a drain
      intr = 1'b1;
      cycle();
      intr = 1'b0;
      cycle();
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      check_eq("arst_ctl",   32'(ctl_bus),   32'd0);
      check_eq("arst_cnt",   32'(stall_cnt), 32'd0);
      check_eq("arst_err",   32'(mem_err),   32'd0);
      check_eq("arst_state", 32'(state_dbg), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      ack_idx = -1;
      for (int i = 0; i < 6; i++) begin
         cycle();
         if (obs_ctl[0]) ack_idx = i;
      end
      check_eq("arst_no_ack", 32'(ack_idx), 32'hFFFF_FFFF);

      // randomized traffic; ready probability varies so timeouts occur
      ready_pct = 50;
      for (int i = 0; i < 3000; i++) begin
         if (i % 250 == 0) begin
            case ($urandom_range(0, 2))
               0:       ready_pct = 60;
               1:       ready_pct = 10;
               default: ready_pct = 0;
            endcase
         end
         rs1_D          = 2'($urandom_range(0, 3));
         rs2_D          = 2'($urandom_range(0, 3));
         rd_E           = 2'($urandom_range(0, 3));
         rs1_used_D     = 1'($urandom_range(0, 1));
         rs2_used_D     = 1'($urandom_range(0, 1));
         rd_en_E        = 1'($urandom_range(0, 1));
         wr_en_regf_E   = 1'($urandom_range(0, 1));
         branch_taken_E = ($urandom_range(0, 99) < 15);
         mem_req_M      = ($urandom_range(0, 99) < 25);
         mem_ready      = ($urandom_range(0, 99) < ready_pct);
         intr           = ($urandom_range(0, 99) < 20);
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_sequencer.md
# hazard_sequencer

Pipeline control block for the 8-bit pipelined processor. It produces stall, flush and bubble controls for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It handles load-use hazards, multi-cycle data-memory waits with timeout, taken-branch flushes and interrupt entry. It sits beside the datapath, reads hazard sources from the D, E and M stages, and drives the enable/clear inputs of each stage register.

## Interface
- MEM_TIMEOUT, 15: max MEM_WAIT cycles before forced release (1..255)
- DRAIN_CYCLES, 3: cycles of fetch suppression before interrupt vectoring (1..7)
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; one clock; reset is asynchronous and active-low
- rs1_D, rs2_D  in  2 each  source register addresses in decode
- rs1_used_D, rs2_used_D  in  1 each  source actually read by decode instruction
- rd_E  in  2  destination register in execute
- rd_en_E  in  1  execute instruction is a memory load
- wr_en_regf_E  in  1  execute instruction writes register file
- branch_taken_E  in  1  branch resolved taken in execute
- mem_req_M  in  1  memory stage accessing data memory
- mem_ready  in  1  data memory completes access this cycle
- intr  in  1  level interrupt request
- stall_F, stall_D, stall_E, stall_M  out  1 each  hold PC / IF-ID / ID-EX / EX-MEM
- flush_D, flush_E  out  1 each  clear IF/ID, ID/EX to NOP next edge
- bubble_W  out  1  force MEM/WB control bits (wr_en_regf, rd_en, out_port_sel) to 0
- pc_sel_intr  out  1  select interrupt vector as next PC
- int_ack  out  1  one-cycle interrupt acknowledge
- mem_err  out  1  sticky: a memory wait timed out
- stall_cnt  out  8  saturating count of stall cycles

## Operation
- FSM states: RUN, MEM_WAIT, INT_DRAIN, INT_VEC. Reset state RUN.
- Outputs are combinational from state and inputs. mem_err, stall_cnt and the counters are registered.
- RUN priority, highest first:
  - Memory wait: mem_req_M && !mem_ready. Assert stall_F/D/E/M and bubble_W. Go to MEM_WAIT with wait_cnt=1.
  - Branch: branch_taken_E. Assert flush_D and flush_E. A coincident load-use condition is ignored because the decode instruction is wrong-path.
  - Load-use: rd_en_E && wr_en_regf_E && ((rd_E==rs1_D && rs1_used_D) || (rd_E==rs2_D && rs2_used_D)). Assert stall_F, stall_D, flush_E for exactly one cycle. The load advances, and the hazard clears next cycle.
  - Interrupt: intr high with none of the above. Go to INT_DRAIN with drain_cnt=0.
- MEM_WAIT:
  - Same outputs as memory wait. wait_cnt increments each cycle.
  - mem_ready=1: drop all stalls this cycle and return to RUN.
  - wait_cnt==MEM_TIMEOUT without ready: set mem_err, drop stalls and return to RUN.
  - Branch and interrupt inputs are ignored; they are held in the frozen stages.
- INT_DRAIN:
  - Assert stall_F and flush_D each cycle so no new instructions enter. Older instructions drain.
  - A memory wait during drain freezes the pipeline exactly as in RUN and pauses drain_cnt, but the state does not change.
  - After DRAIN_CYCLES counted cycles, go to INT_VEC.
  - intr deasserting mid-drain does not abort.
- INT_VEC: one cycle. pc_sel_intr=1, int_ack=1, flush_D=1. Then return to RUN.
- stall_cnt increments in any cycle where stall_F=1. It saturates at 255.
- mem_err clears only on reset.

## Timing
- All state, counters, mem_err and stall_cnt update on the rising clk edge.
- While reset=0: state=RUN, counters=0, mem_err=0, stall_cnt=0, and all outputs forced 0.
- A reset assertion mid-MEM_WAIT or mid-INT_DRAIN returns to RUN immediately; no int_ack is issued.
- Load-use stall latency: 1 cycle. Branch penalty: 2 flushed slots.
- Memory wait: stalls are asserted the same cycle mem_req_M && !mem_ready is seen. They release in the cycle mem_ready=1.
- Interrupt latency from intr sampled in RUN to int_ack: DRAIN_CYCLES+1 cycles, plus any memory-wait cycles during drain.
- mem_ready asserted in the same cycle as mem_req_M causes no stall.

## Test plan
- Load-use:
  - Stimulus: rd_en_E=1, wr_en_regf_E=1, rd_E=2, rs1_D=2, rs1_used_D=1.
  - Required: one cycle of stall_F=stall_D=flush_E=1, then all 0; stall_cnt=1.
  - Repeat with rs1_used_D=0: no stall.
- Branch plus load-use in the same cycle:
  - Stimulus: load-use condition and branch_taken_E=1 together.
  - Required: flush_D=flush_E=1, stall_F=0, stall_cnt unchanged.
- Memory wait:
  - Stimulus: mem_req_M=1, mem_ready=0 for 4 cycles, then 1.
  - Required: stall_F/D/E/M and bubble_W high for 4 cycles and low on the 5th; state back to RUN; stall_cnt=4.
- Timeout:
  - Stimulus: MEM_TIMEOUT=15, mem_ready held 0.
  - Required: stalls drop after 15 cycles; mem_err=1 and stays 1 until reset.
- Interrupt:
  - Stimulus: intr=1 in idle RUN with DRAIN_CYCLES=3.
  - Required: 3 cycles of stall_F=flush_D=1, then one cycle of pc_sel_intr=int_ack=1, then RUN.
  - Repeat with a 2-cycle memory wait during drain: int_ack is delayed by 2 cycles.
- Reset:
  - Stimulus: reset=0 asserted asynchronously mid-INT_DRAIN.
  - Required: all outputs 0 immediately; after release, RUN with no int_ack; stall_cnt=0; mem_err=0.
